fpga_config_loader: RTL and testbench
=====================================

// Module: fpga_config_loader
// PURPOSE
//   Streams the configuration image into the FPGA fabric's LUTs and switch boxes.
//   Sits directly upstream of the FPGA top, feeding the LUT 'mem' and switch-box
//   'configure' registers, and replaces direct hierarchical preloading of the fabric.
//   The image is 32-bit words arriving over a valid/ready stream; the loader holds
//   the fabric in reset-equivalent state until the load completes.
// PARAMETERS
//   NUM_LUT  11  number of LUT instances (33-bit mem: 32 truth bits + bit 32 FF-select)
//   NUM_SB   20  number of switch-box instances (32-bit configure)
//   WORD_W   32  configuration word width
// PORTS
//   clock      in   1                        system clock, rising edge
//   reset      in   1                        synchronous, active-high
//   cfg_start  in   1                        pulse: begin a new load
//   cfg_data   in   WORD_W                   configuration word
//   cfg_valid  in   1                        cfg_data valid
//   cfg_ready  out  1                        loader accepts word this cycle
//   lut_cfg    out  NUM_LUT*(WORD_W+1)       LUT k at [k*33 +: 33]
//   sb_cfg     out  NUM_SB*WORD_W            SB k at [k*32 +: 32]
//   cfg_busy   out  1                        load in progress; fabric must ignore outputs
//   cfg_done   out  1                        image loaded and valid (sticky)
//   cfg_err    out  1                        load failed (sticky)
//   word_idx   out  6                        index of next expected word
// BEHAVIOUR
//   - Reset: all outputs 0, state IDLE. Reset mid-load aborts; no partial state kept.
//   - States: IDLE -> LOAD_LUT -> LOAD_SB -> LOAD_FF -> [CHECK] -> DONE; ERROR reachable
//     from CHECK only. cfg_start in IDLE/DONE/ERROR: clear lut_cfg, sb_cfg, done,
//     err, word_idx; go to LOAD_LUT next cycle. cfg_start while busy is ignored.
//   - A word is accepted on a rising edge with cfg_valid && cfg_ready. cfg_ready = 1 only
//     in LOAD_* / CHECK states. Accepted word lands in its output register the next edge.
//   - Word map (N = 2*NUM_LUT + NUM_SB = 42): idx 0..10 -> lut_cfg[k][31:0];
//     idx 11..30 -> sb_cfg[idx-11]; idx 31..41 -> lut_cfg[idx-31][32] = cfg_data[31]
//     (other bits ignored). Transition on accept of last word of each section.
//   - FF-select bits remain 0 until LOAD_FF so no LUT registers while partially configured.
//   - cfg_valid gaps are allowed anywhere; the state and index hold.
//   - cfg_busy = 1 from the cycle after cfg_start until DONE/ERROR is entered.
//   - cfg_done rises on the cycle after the last required word is accepted.
//   - word_idx saturates at N (or N+1 with checksum); there is no wrap-around.
// CONFIGURATION
//   CFG_CHECKSUM_EN defined: after idx 41, CHECK expects one extra word equal to the XOR
//     of all 42 words. On match -> DONE; on mismatch -> ERROR (cfg_err=1, cfg_done=0,
//     lut_cfg/sb_cfg retain loaded values, cfg_busy=0).
//   Not defined: no CHECK state; LOAD_FF exits directly to DONE; cfg_err is tied to 0.
// STRUCTURE
//   Shared package fpga_cfg_pkg: state enum, NUM_LUT/NUM_SB/WORD_W, section base
//     indices (LUT_BASE=0, SB_BASE=11, FF_BASE=31, CFG_WORDS=42).
//   One sub-module: cfg_xor_accum (running XOR of accepted words; clear on start),
//     instantiated only under CFG_CHECKSUM_EN.
// TESTING
//   1. Start, 42 back-to-back words w[i]=32'hA500_0000+i, word 31=32'h8000_0000 ->
//      lut_cfg LUT0 = {1'b1,32'hA500_0000}, SB0 = 32'hA500_000B, done 1 cycle after 42nd.
//   2. Same image with cfg_valid low every other cycle -> identical outputs; busy stays high
//      throughout; word_idx holds during gaps.
//   3. Reset asserted after word 20 -> next cycle all outputs 0, cfg_ready=0; a new start
//      with a full image loads cleanly.
//   4. cfg_start pulsed at word 5 -> ignored; word_idx continues 6; load completes normally.
//   5. CFG_CHECKSUM_EN: correct XOR as word 43 -> cfg_done=1; XOR^1 -> cfg_err=1, done=0.
//   6. Load BCD-adder image, release to fabric, apply 9+6 cin=0 -> cout,sum = 1 0101.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the FPGA configuration loader.
// Word map: LUT truth words, switch-box words, then LUT FF-select words.
package fpga_cfg_pkg;

  localparam int NUM_LUT   = 11;
  localparam int NUM_SB    = 20;
  localparam int WORD_W    = 32;
  localparam int LUT_W     = WORD_W + 1;

  localparam int LUT_BASE  = 0;
  localparam int SB_BASE   = 11;
  localparam int FF_BASE   = 31;
  localparam int CFG_WORDS = 42;

  typedef logic [5:0] idx_t;

  localparam idx_t LUT_LAST = idx_t'(SB_BASE - 1);
  localparam idx_t SB_LAST  = idx_t'(FF_BASE - 1);
  localparam idx_t FF_LAST  = idx_t'(CFG_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_LUT,
    S_LOAD_SB,
    S_LOAD_FF,
    S_CHECK,
    S_DONE,
    S_ERROR
  } cfg_state_t;

endpackage

// File: rtl/fpga_config_loader_xor.sv
// cfg_xor_accum: running XOR of accepted configuration words.
// Ports: clock, reset, clear (new load), en (word accepted), data, acc.
module cfg_xor_accum
  import fpga_cfg_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [WORD_W-1:0] data,
  output logic [WORD_W-1:0] acc
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ data;
    end
  end

endmodule

// File: rtl/fpga_config_loader.sv
// fpga_config_loader: streams a 42-word image into LUT/switch-box config regs.
// Ports: clock, reset, cfg_start, cfg_data/valid/ready stream, lut_cfg, sb_cfg,
// cfg_busy, cfg_done, cfg_err, word_idx. Define CFG_CHECKSUM_EN to require
// a trailing XOR checksum word (CHECK state, cfg_err, cfg_xor_accum).
module fpga_config_loader
  import fpga_cfg_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cfg_start,
  input  logic [WORD_W-1:0]         cfg_data,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  output logic [NUM_LUT*LUT_W-1:0]  lut_cfg,
  output logic [NUM_SB*WORD_W-1:0]  sb_cfg,
  output logic                      cfg_busy,
  output logic                      cfg_done,
  output logic                      cfg_err,
  output logic [5:0]                word_idx
);

  cfg_state_t        state;
  logic [LUT_W-1:0]  lut_q [NUM_LUT];
  logic [WORD_W-1:0] sb_q  [NUM_SB];
  idx_t              idx_q;
  logic              done_q;
  logic              accept;
  logic              start_ok;
  logic [3:0]        lut_k;
  logic [4:0]        sb_k;
  logic [3:0]        ff_k;

  assign cfg_ready = state inside {S_LOAD_LUT, S_LOAD_SB,
                                   S_LOAD_FF, S_CHECK};
  assign cfg_busy  = cfg_ready;
  assign accept    = cfg_valid && cfg_ready;
  assign start_ok  = cfg_start &&
                     (state inside {S_IDLE, S_DONE, S_ERROR});

  assign lut_k = 4'(idx_q);
  assign sb_k  = 5'(idx_q - idx_t'(SB_BASE));
  assign ff_k  = 4'(idx_q - idx_t'(FF_BASE));

`ifdef CFG_CHECKSUM_EN
  logic              err_q;
  logic [WORD_W-1:0] xor_acc;

  // Checksum word itself is not folded into the running XOR.
  cfg_xor_accum u_xor (
    .clock (clock),
    .reset (reset),
    .clear (start_ok),
    .en    (accept && (state != S_CHECK)),
    .data  (cfg_data),
    .acc   (xor_acc)
  );

  assign cfg_err = err_q;
`else
  assign cfg_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset || start_ok) begin
      state  <= reset ? S_IDLE : S_LOAD_LUT;
      idx_q  <= '0;
      done_q <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      err_q  <= 1'b0;
`endif
      for (int k = 0; k < NUM_LUT; k++) lut_q[k] <= '0;
      for (int k = 0; k < NUM_SB; k++)  sb_q[k]  <= '0;
    end else if (accept) begin
      idx_q <= idx_q + 6'd1;
      unique case (state)
        S_LOAD_LUT: begin
          lut_q[lut_k][WORD_W-1:0] <= cfg_data;
          if (idx_q == LUT_LAST) state <= S_LOAD_SB;
        end
        S_LOAD_SB: begin
          sb_q[sb_k] <= cfg_data;
          if (idx_q == SB_LAST) state <= S_LOAD_FF;
        end
        S_LOAD_FF: begin
          // Only the MSB carries the FF-select bit.
          lut_q[ff_k][WORD_W] <= cfg_data[WORD_W-1];
          if (idx_q == FF_LAST) begin
`ifdef CFG_CHECKSUM_EN
            state  <= S_CHECK;
`else
            state  <= S_DONE;
            done_q <= 1'b1;
`endif
          end
        end
`ifdef CFG_CHECKSUM_EN
        S_CHECK: begin
          if (cfg_data == xor_acc) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end else begin
            state  <= S_ERROR;
            err_q  <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign cfg_done = done_q;
  assign word_idx = idx_q;

  for (genvar k = 0; k < NUM_LUT; k++) begin : g_lut
    assign lut_cfg[k*LUT_W +: LUT_W] = lut_q[k];
  end

  for (genvar k = 0; k < NUM_SB; k++) begin : g_sb
    assign sb_cfg[k*WORD_W +: WORD_W] = sb_q[k];
  end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Directed self-checking bench for fpga_config_loader.
// Define CFG_CHECKSUM_EN to exercise the checksum word path.
module tb_fpga_config_loader;
  import fpga_cfg_pkg::*;

`ifdef CFG_CHECKSUM_EN
  localparam int NW = CFG_WORDS + 1;
`else
  localparam int NW = CFG_WORDS;
`endif

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     cfg_start;
  logic [WORD_W-1:0]        cfg_data;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [NUM_LUT*LUT_W-1:0] lut_cfg;
  logic [NUM_SB*WORD_W-1:0] sb_cfg;
  logic                     cfg_busy;
  logic                     cfg_done;
  logic                     cfg_err;
  logic [5:0]               word_idx;

  int checks   = 0;
  int failures = 0;

  logic [31:0] img [CFG_WORDS];

  always #5 clock = ~clock;

  fpga_config_loader dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_start (cfg_start),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .lut_cfg   (lut_cfg),
    .sb_cfg    (sb_cfg),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .word_idx  (word_idx)
  );

  function automatic logic [NUM_LUT*LUT_W-1:0] exp_lut();
    logic [NUM_LUT*LUT_W-1:0] v;
    for (int k = 0; k < NUM_LUT; k++)
      v[k*LUT_W +: LUT_W] = {img[FF_BASE+k][31], img[k]};
    return v;
  endfunction

  function automatic logic [NUM_SB*WORD_W-1:0] exp_sb();
    logic [NUM_SB*WORD_W-1:0] v;
    for (int k = 0; k < NUM_SB; k++)
      v[k*WORD_W +: WORD_W] = img[SB_BASE+k];
    return v;
  endfunction

  function automatic logic [31:0] img_xor();
    logic [31:0] x = '0;
    for (int i = 0; i < CFG_WORDS; i++) x ^= img[i];
    return x;
  endfunction

  // Truth table of one output bit of a BCD add a + 6 + cin, addr = {a, cin}.
  function automatic logic [31:0] bcd_tt(input int bitk);
    logic [31:0] tt = '0;
    for (int addr = 0; addr < 32; addr++) begin
      int a = addr >> 1;
      int c = addr & 1;
      int s = a + 6 + c;
      int r = (s > 9) ? (16 + s - 10) : s;
      tt[addr] = 1'((r >> bitk) & 1);
    end
    return tt;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    cfg_data  = w;
    cfg_valid = 1'b1;
    while (cfg_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout ready=%b required=1", cfg_ready);
    end
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic start_load();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send_image();
    for (int i = 0; i < CFG_WORDS; i++) send_word(img[i]);
`ifdef CFG_CHECKSUM_EN
    send_word(img_xor());
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({cfg_busy, cfg_done, cfg_err, cfg_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b required=0000",
               {cfg_busy, cfg_done, cfg_err, cfg_ready});
    end
    checks++;
    if (lut_cfg !== '0 || sb_cfg !== '0 || word_idx !== 6'd0) begin
      failures++;
      $display("FAIL reset_regs idx=%0d required=0 (cfg regs nonzero?)",
               word_idx);
    end
  endtask

  task automatic test_basic_load();
    logic [NUM_LUT-1:0] ff;
    for (int i = 0; i < CFG_WORDS; i++) img[i] = 32'hA500_0000 + i;
    img[31] = 32'h8000_0000;
    start_load();
    checks++;
    if (cfg_busy !== 1'b1 || word_idx !== 6'd0) begin
      failures++;
      $display("FAIL start_busy busy=%b idx=%0d required=1,0",
               cfg_busy, word_idx);
    end
    for (int i = 0; i < FF_BASE; i++) send_word(img[i]);
    for (int k = 0; k < NUM_LUT; k++) ff[k] = lut_cfg[k*LUT_W+WORD_W];
    checks++;
    if (ff !== '0) begin
      failures++;
      $display("FAIL ff_early got=%h required=0", ff);
    end
    for (int i = FF_BASE; i < CFG_WORDS - 1; i++) send_word(img[i]);
    checks++;
    if (cfg_done !== 1'b0 || cfg_busy !== 1'b1) begin
      failures++;
      $display("FAIL done_early done=%b busy=%b required=0,1",
               cfg_done, cfg_busy);
    end
    send_word(img[CFG_WORDS-1]);
`ifdef CFG_CHECKSUM_EN
    checks++;
    if (cfg_done !== 1'b0 || word_idx !== 6'd42) begin
      failures++;
      $display("FAIL check_wait done=%b idx=%0d required=0,42",
               cfg_done, word_idx);
    end
    send_word(img_xor());
`endif
    checks++;
    if (cfg_done !== 1'b1 || cfg_busy !== 1'b0 || cfg_err !== 1'b0 ||
        word_idx !== 6'(NW)) begin
      failures++;
      $display("FAIL done_flags done=%b busy=%b err=%b idx=%0d required=1,0,0,%0d",
               cfg_done, cfg_busy, cfg_err, word_idx, NW);
    end
    checks++;
    if (lut_cfg[32:0] !== {1'b1, 32'hA500_0000}) begin
      failures++;
      $display("FAIL lut0 got=%h required=1a5000000", lut_cfg[32:0]);
    end
    checks++;
    if (sb_cfg[31:0] !== 32'hA500_000B) begin
      failures++;
      $display("FAIL sb0 got=%h required=a500000b", sb_cfg[31:0]);
    end
    checks++;
    if (lut_cfg !== exp_lut() || sb_cfg !== exp_sb()) begin
      failures++;
      $display("FAIL basic_image lut=%h required=%h", lut_cfg, exp_lut());
    end
  endtask

  task automatic test_gaps();
    int bad = 0;
    for (int i = 0; i < CFG_WORDS; i++) img[i] = 32'hA500_0000 + i;
    img[31] = 32'h8000_0000;
    start_load();
    for (int i = 0; i < CFG_WORDS; i++) begin
      send_word(img[i]);
      if (i < CFG_WORDS - 1) begin
        tick();
        if (cfg_busy !== 1'b1 || word_idx !== 6'(i + 1)) bad++;
      end
    end
`ifdef CFG_CHECKSUM_EN
    send_word(img_xor());
`endif
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL gap_hold bad_cycles=%0d required=0", bad);
    end
    checks++;
    if (lut_cfg !== exp_lut() || sb_cfg !== exp_sb() || cfg_done !== 1'b1) begin
      failures++;
      $display("FAIL gap_image done=%b lut=%h required=1,%h",
               cfg_done, lut_cfg, exp_lut());
    end
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < CFG_WORDS; i++) img[i] = ~(32'h1357_0000 + i * 3);
    start_load();
    for (int i = 0; i <= 20; i++) send_word(img[i]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (lut_cfg !== '0 || sb_cfg !== '0 || word_idx !== 6'd0 ||
        {cfg_busy, cfg_done, cfg_err, cfg_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL midload_reset idx=%0d flags=%b required=0,0000",
               word_idx, {cfg_busy, cfg_done, cfg_err, cfg_ready});
    end
    start_load();
    send_image();
    checks++;
    if (lut_cfg !== exp_lut() || sb_cfg !== exp_sb() || cfg_done !== 1'b1) begin
      failures++;
      $display("FAIL reload_image done=%b sb=%h required=1,%h",
               cfg_done, sb_cfg, exp_sb());
    end
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < CFG_WORDS; i++) img[i] = 32'h0F0F_0000 ^ (i << 9);
    img[33] = 32'hFFFF_FFFF;
    start_load();
    for (int i = 0; i < 5; i++) send_word(img[i]);
    cfg_start = 1'b1;
    send_word(img[5]);
    cfg_start = 1'b0;
    checks++;
    if (word_idx !== 6'd6 || cfg_busy !== 1'b1) begin
      failures++;
      $display("FAIL start_busy_ignored idx=%0d busy=%b required=6,1",
               word_idx, cfg_busy);
    end
    for (int i = 6; i < CFG_WORDS; i++) send_word(img[i]);
`ifdef CFG_CHECKSUM_EN
    send_word(img_xor());
`endif
    checks++;
    if (lut_cfg !== exp_lut() || sb_cfg !== exp_sb() || cfg_done !== 1'b1) begin
      failures++;
      $display("FAIL start_ign_image done=%b lut=%h required=1,%h",
               cfg_done, lut_cfg, exp_lut());
    end
  endtask

`ifdef CFG_CHECKSUM_EN
  task automatic test_checksum();
    for (int i = 0; i < CFG_WORDS; i++) img[i] = 32'h6000_0001 * (i + 7);
    start_load();
    for (int i = 0; i < CFG_WORDS; i++) send_word(img[i]);
    send_word(img_xor() ^ 32'h1);
    checks++;
    if ({cfg_err, cfg_done, cfg_busy} !== 3'b100 || word_idx !== 6'd43) begin
      failures++;
      $display("FAIL checksum_bad err,done,busy=%b idx=%0d required=100,43",
               {cfg_err, cfg_done, cfg_busy}, word_idx);
    end
    checks++;
    if (lut_cfg !== exp_lut() || sb_cfg !== exp_sb()) begin
      failures++;
      $display("FAIL checksum_retain lut=%h required=%h", lut_cfg, exp_lut());
    end
    start_load();
    send_image();
    checks++;
    if ({cfg_err, cfg_done} !== 2'b01) begin
      failures++;
      $display("FAIL checksum_good err,done=%b required=01",
               {cfg_err, cfg_done});
    end
  endtask
`endif

  task automatic test_bcd();
    logic [4:0] got;
    for (int i = 0; i < CFG_WORDS; i++) img[i] = '0;
    for (int k = 0; k < 5; k++) img[k] = bcd_tt(k);
    start_load();
    send_image();
    // a=9, cin=0 -> addr 18; expect cout,sum = 1 0101
    for (int k = 0; k < 5; k++) got[k] = lut_cfg[k*LUT_W + 18];
    checks++;
    if (cfg_done !== 1'b1 || got !== 5'b10101) begin
      failures++;
      $display("FAIL bcd_9p6 done=%b got=%b required=1,10101", cfg_done, got);
    end
    // a=2, cin=1 -> addr 5; 2+6+1 = 9 -> 0 1001
    for (int k = 0; k < 5; k++) got[k] = lut_cfg[k*LUT_W + 5];
    checks++;
    if (got !== 5'b01001) begin
      failures++;
      $display("FAIL bcd_2p6c got=%b required=01001", got);
    end
  endtask

  initial begin
    reset     = 1'b1;
    cfg_start = 1'b0;
    cfg_data  = '0;
    cfg_valid = 1'b0;
    test_reset();
    test_basic_load();
    test_gaps();
    test_reset_midload();
    test_start_ignored();
`ifdef CFG_CHECKSUM_EN
    test_checksum();
`endif
    test_bcd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
